serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor. It is the inverse-operation companion to the team's full-adder cell.
- Computes diff = a - b - bin, LSB first, one bit per clock, using a combinational full-subtractor cell and a registered borrow.
- Uses a start/busy/done handshake, so it sits beside the arithmetic datapath wherever area matters more than latency.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only while busy=0
- a  input  WIDTH  minuend; captured on the accepted start edge
- b  input  WIDTH  subtrahend; captured on the accepted start edge
- bin  input  1  borrow-in; captured on the accepted start edge
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse; diff and bout are valid from this cycle
- diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH
- bout  output  1  final borrow-out; 1 when a < b + bin as unsigned values

Behaviour:
- Reset (asynchronous, while rst_n=0):
  - busy=0, done=0, diff=0, bout=0.
  - Internal shift registers, borrow register and bit counter cleared; FSM returns to IDLE.
- FSM states: IDLE, RUN.
- IDLE:
  - On an edge with start=1: load a_sh<=a, b_sh<=b, borrow<=bin, cnt<=0, busy<=1, go to RUN.
- RUN, each edge:
  - d = a_sh[0] ^ b_sh[0] ^ borrow
  - borrow <= (~a_sh[0] & b_sh[0]) | (~a_sh[0] & borrow) | (b_sh[0] & borrow)
  - a_sh and b_sh shift right by one.
  - d shifts into the MSB of the result shift register.
  - cnt increments.
- Completion, on the edge where cnt==WIDTH-1:
  - diff <= completed result.
  - bout <= new borrow.
  - busy <= 0, done <= 1, go to IDLE.
- Latency:
  - Start accepted at edge E0; done=1 in the cycle after edge E(WIDTH).
  - Total WIDTH+1 edges from start to result.
- Output holding:
  - done is high for exactly one cycle.
  - diff and bout hold their values until the next completion or reset. They are not cleared on start.
- Boundary conditions:
  - start while busy=1: ignored. Operands are not re-captured and the result is unaffected.
  - start high in the done cycle: accepted (FSM is in IDLE). Back-to-back throughput is one operation per WIDTH+1 cycles.
  - start held high continuously: the block re-triggers every WIDTH+1 cycles.
  - Reset asserted mid-operation: the operation is aborted, done is never pulsed, and all outputs return to 0.
  - Counter width is $clog2(WIDTH). No wrap-around of cnt beyond WIDTH-1.

Optional Feature:
- Macro: SERIAL_SUB_OVERFLOW_EN.
- With the macro defined:
  - Adds output port ovf (1 bit, reset 0), registered at completion alongside diff.
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the captured operands. This is two's-complement signed overflow.
  - ovf holds with diff.
- Without the macro: the port and the MSB capture registers are absent; all other behaviour is identical.

Decomposition:
- Shared package arith_pkg:
  - FSM state enum (IDLE, RUN).
  - Default width constant SUB_WIDTH_DEF = 8.
- One sub-module: full_subtractor.
  - Inputs x, y, bin; outputs d, bout; purely combinational.
  - Instantiated once per bit slice.
  - Unit-testable exhaustively: 8 input combinations.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, bin=0, start one cycle -> busy high for 8 cycles; done pulses 9 edges after start; diff=0x02, bout=0.
- a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1. Then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1. Then a=0xFF, b=0xFF, bin=1 -> diff=0xFF, bout=1.
- a=0x10, b=0x01 started; start pulsed again on cycle 3 with a=0xAA, b=0x55 -> ignored; diff=0x0F; exactly one done pulse.
- start held high across two operations (0x09-0x04, then 0x20-0x21) -> done pulses at +9 and +18 edges; diff=0x05 bout=0, then diff=0xFF bout=1.
- rst_n low at cycle 4 of 0x80-0x01 -> busy, done, diff and bout all 0 immediately; no done pulse after release; next start runs normally.
- SERIAL_SUB_OVERFLOW_EN defined:
  - a=0x80, b=0x01 -> diff=0x7F, ovf=1.
  - a=0x7F, b=0x01 -> diff=0x7E, ovf=0.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: sequencer states and default operand width
// for the bit-serial arithmetic cells.
package arith_pkg;

  localparam int SUB_WIDTH_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sub_state_e;

endpackage : arith_pkg

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus of the serial subtractor.
// SERIAL_SUB_OVERFLOW_EN adds the signed-overflow flag ovf.
interface serial_subtractor_if #(
  parameter int WIDTH = arith_pkg::SUB_WIDTH_DEF
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             ovf;

  modport master (output start, a, b, bin, input  busy, done, diff, bout, ovf);
  modport slave  (input  start, a, b, bin, output busy, done, diff, bout, ovf);
`else
  modport master (output start, a, b, bin, input  busy, done, diff, bout);
  modport slave  (input  start, a, b, bin, output busy, done, diff, bout);
`endif

endinterface : serial_subtractor_if

// File: rtl/full_subtractor.sv
// One-bit combinational full subtractor: d = x - y - bin, bout = borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, diff = a - b - bin, LSB first, one bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  sub_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic             done_q, done_d;
  logic             fs_d, fs_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  full_subtractor u_fs (
    .x    (a_sh_q[0]),
    .y    (b_sh_q[0]),
    .bin  (borrow_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    done_d   = 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d   = bus.a;
          b_sh_d   = bus.b;
          borrow_d = bus.bin;
          cnt_d    = '0;
          state_d  = RUN;
`ifdef SERIAL_SUB_OVERFLOW_EN
          a_msb_d  = bus.a[WIDTH-1];
          b_msb_d  = bus.b[WIDTH-1];
`endif
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        borrow_d = fs_bout;
        res_d    = {fs_d, res_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Last slice: publish the assembled result and return to idle.
          diff_d  = res_d;
          bout_d  = fs_bout;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
`ifdef SERIAL_SUB_OVERFLOW_EN
          ovf_d   = (a_msb_q != b_msb_q) && (fs_d != a_msb_q);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      done_q   <= done_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8) and its full_subtractor cell.
module tb_serial_subtractor;
  import arith_pkg::*;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic fx, fy, fb, fd, fbo;
  full_subtractor u_cell (.x(fx), .y(fy), .bin(fb), .d(fd), .bout(fbo));

  always #5 clk = ~clk;

  // Called 1 time unit after an edge; returns 1 time unit after the accepting edge E0.
  task automatic pulse_start(input logic [7:0] av, input logic [7:0] bv, input logic bi);
    bus.a     = av;
    bus.b     = bv;
    bus.bin   = bi;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Observes up to 30 edges after E0: first done edge index, busy cycles, done pulse count.
  task automatic observe(output int done_edge, output int busy_n, output int pulses);
    done_edge = 0;
    pulses    = 0;
    busy_n    = bus.busy ? 1 : 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.busy) busy_n++;
      if (bus.done) begin
        pulses++;
        if (done_edge == 0) done_edge = i;
      end
    end
  endtask

  task automatic test_full_subtractor();
    for (int i = 0; i < 8; i++) begin
      int r;
      logic [2:0] v;
      v  = 3'(i);
      fx = v[2];
      fy = v[1];
      fb = v[0];
      #1;
      r = int'(fx) - int'(fy) - int'(fb);
      total++;
      if ({fbo, fd} !== {logic'(r < 0), logic'(r & 1)}) begin
        bad++;
        $display("FAIL cell x%0d y%0d b%0d: got bout=%b d=%b want bout=%b d=%b",
                 fx, fy, fb, fbo, fd, r < 0, r & 1);
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    #12;
    total++;
    if ({bus.busy, bus.done, bus.diff, bus.bout} !== 11'b0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b diff=%h bout=%b want all 0",
               bus.busy, bus.done, bus.diff, bus.bout);
    end
`ifdef SERIAL_SUB_OVERFLOW_EN
    total++;
    if (bus.ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_ovf: got %b want 0", bus.ovf);
    end
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int de, bn, pn;
    pulse_start(8'h05, 8'h03, 1'b0);
    observe(de, bn, pn);
    total++;
    if (de !== 8) begin bad++; $display("FAIL basic_latency: got edge %0d want 8", de); end
    total++;
    if (bn !== 8) begin bad++; $display("FAIL basic_busy_cycles: got %0d want 8", bn); end
    total++;
    if (pn !== 1) begin bad++; $display("FAIL basic_done_pulses: got %0d want 1", pn); end
    total++;
    if ({bus.bout, bus.diff} !== {1'b0, 8'h02}) begin
      bad++;
      $display("FAIL basic_result: got bout=%b diff=%h want bout=0 diff=02", bus.bout, bus.diff);
    end
  endtask

  task automatic test_borrow();
    logic [7:0] av [3] = '{8'h03, 8'h00, 8'hFF};
    logic [7:0] bv [3] = '{8'h05, 8'h00, 8'hFF};
    logic       iv [3] = '{1'b0, 1'b1, 1'b1};
    logic [7:0] ed [3] = '{8'hFE, 8'hFF, 8'hFF};
    logic       eb [3] = '{1'b1, 1'b1, 1'b1};
    logic [7:0] prev;
    int de, bn, pn;
    prev = 8'h02;
    for (int k = 0; k < 3; k++) begin
      pulse_start(av[k], bv[k], iv[k]);
      total++;
      if (bus.diff !== prev) begin
        bad++;
        $display("FAIL borrow_hold_%0d: got diff=%h want %h", k, bus.diff, prev);
      end
      observe(de, bn, pn);
      total++;
      if ({bus.bout, bus.diff, de} !== {eb[k], ed[k], 8}) begin
        bad++;
        $display("FAIL borrow_%0d: got bout=%b diff=%h edge=%0d want bout=%b diff=%h edge=8",
                 k, bus.bout, bus.diff, de, eb[k], ed[k]);
      end
      prev = ed[k];
    end
  endtask

  task automatic test_start_ignored();
    int pn = 0;
    int de = 0;
    pulse_start(8'h10, 8'h01, 1'b0);
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin pn++; if (de == 0) de = i; end
      if (i == 2) begin bus.a = 8'hAA; bus.b = 8'h55; bus.start = 1'b1; end
      if (i == 3) bus.start = 1'b0;
    end
    total++;
    if (pn !== 1 || de !== 8) begin
      bad++;
      $display("FAIL ignored_done: got pulses=%0d edge=%0d want pulses=1 edge=8", pn, de);
    end
    total++;
    if ({bus.bout, bus.diff} !== {1'b0, 8'h0F}) begin
      bad++;
      $display("FAIL ignored_result: got bout=%b diff=%h want bout=0 diff=0f", bus.bout, bus.diff);
    end
  endtask

  task automatic test_back_to_back();
    int d1 = 0, d2 = 0, pn = 0;
    logic [8:0] r1 = '0, r2 = '0;
    bus.a = 8'h09; bus.b = 8'h04; bus.bin = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.a = 8'h20; bus.b = 8'h21;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        pn++;
        if (pn == 1) begin d1 = i; r1 = {bus.bout, bus.diff}; end
        if (pn == 2) begin d2 = i; r2 = {bus.bout, bus.diff}; end
      end
      if (i == 9) bus.start = 1'b0;
    end
    total++;
    if (pn !== 2 || d1 !== 8 || d2 !== 17) begin
      bad++;
      $display("FAIL b2b_timing: got pulses=%0d edges=%0d,%0d want 2 at 8,17", pn, d1, d2);
    end
    total++;
    if (r1 !== {1'b0, 8'h05}) begin
      bad++;
      $display("FAIL b2b_first: got bout=%b diff=%h want bout=0 diff=05", r1[8], r1[7:0]);
    end
    total++;
    if (r2 !== {1'b1, 8'hFF}) begin
      bad++;
      $display("FAIL b2b_second: got bout=%b diff=%h want bout=1 diff=ff", r2[8], r2[7:0]);
    end
  endtask

  task automatic test_reset_mid();
    int de, bn, pn;
    pulse_start(8'h80, 8'h01, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.busy, bus.done, bus.diff, bus.bout} !== 11'b0) begin
      bad++;
      $display("FAIL midreset_outputs: got busy=%b done=%b diff=%h bout=%b want all 0",
               bus.busy, bus.done, bus.diff, bus.bout);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    observe(de, bn, pn);
    total++;
    if (pn !== 0 || bn !== 0) begin
      bad++;
      $display("FAIL midreset_quiet: got pulses=%0d busy=%0d want 0,0", pn, bn);
    end
    pulse_start(8'h80, 8'h01, 1'b0);
    observe(de, bn, pn);
    total++;
    if ({bus.bout, bus.diff, de, pn} !== {1'b0, 8'h7F, 8, 1}) begin
      bad++;
      $display("FAIL midreset_rerun: got bout=%b diff=%h edge=%0d pulses=%0d want 0 7f 8 1",
               bus.bout, bus.diff, de, pn);
    end
`ifdef SERIAL_SUB_OVERFLOW_EN
    total++;
    if (bus.ovf !== 1'b1) begin bad++; $display("FAIL ovf_80_01: got %b want 1", bus.ovf); end
`endif
  endtask

`ifdef SERIAL_SUB_OVERFLOW_EN
  task automatic test_overflow();
    int de, bn, pn;
    pulse_start(8'h7F, 8'h01, 1'b0);
    observe(de, bn, pn);
    total++;
    if ({bus.ovf, bus.diff} !== {1'b0, 8'h7E}) begin
      bad++;
      $display("FAIL ovf_7f_01: got ovf=%b diff=%h want ovf=0 diff=7e", bus.ovf, bus.diff);
    end
  endtask
`endif

  initial begin
    test_full_subtractor();
    test_reset();
    test_basic();
    test_borrow();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
`ifdef SERIAL_SUB_OVERFLOW_EN
    test_overflow();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_serial_subtractor
